// File: rtl/jtag_bscan_tap_ice1f.sv
// IEEE 1149.1 TAP controller driving the right/bottom I/O column boundary-scan chain.
// Owns the IR, bypass and IDCODE registers, and muxes the chain tail onto tdo.
module jtag_bscan_tap_ice1f #(
  parameter logic [31:0] IDCODE = 32'h1100_0043
) (
  input  logic tclk,
  input  logic trstb,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  output logic sdi,
  input  logic sdo,
  output logic shift,
  output logic update,
  output logic bs_en,
  output logic hiz_b,
  output logic mode
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [3:0] IR_EXTEST = 4'h0;
  localparam logic [3:0] IR_SAMPLE = 4'h1;
  localparam logic [3:0] IR_HIGHZ  = 4'h7;
  localparam logic [3:0] IR_IDCODE = 4'hE;

  tap_state_t  state, next_state;
  logic [3:0]  ir_shift, ir_active;
  logic [31:0] id_reg;
  logic        bypass_reg;
  logic        chain_sel, id_sel, dr_tdo;

  always_ff @(posedge tclk or negedge trstb) begin
    if (!trstb) state <= TLR;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state = tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state = tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  end

  // Unlisted instruction codes fall through to the bypass path.
  assign chain_sel = (ir_active == IR_EXTEST) || (ir_active == IR_SAMPLE);
  assign id_sel    = (ir_active == IR_IDCODE);
  assign dr_tdo    = chain_sel ? sdo : (id_sel ? id_reg[0] : bypass_reg);

  assign sdi    = tdi;
  assign shift  = (state == SH_DR)  && chain_sel;
  assign update = (state == UPD_DR) && chain_sel;

  always_ff @(posedge tclk or negedge trstb) begin
    if (!trstb) begin
      ir_shift   <= 4'b0101;
      ir_active  <= IR_IDCODE;
      id_reg     <= IDCODE;
      bypass_reg <= 1'b0;
    end else begin
      case (state)
        CAP_IR: ir_shift  <= 4'b0101;
        SH_IR:  ir_shift  <= {tdi, ir_shift[3:1]};
        UPD_IR: ir_active <= ir_shift;
        TLR:    ir_active <= IR_IDCODE;
        CAP_DR: begin
          id_reg     <= IDCODE;
          bypass_reg <= 1'b0;
        end
        SH_DR: begin
          id_reg     <= {tdi, id_reg[31:1]};
          bypass_reg <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Pad controls lag the active IR by one edge so they never glitch.
  always_ff @(posedge tclk or negedge trstb) begin
    if (!trstb) begin
      bs_en <= 1'b0;
      hiz_b <= 1'b1;
      mode  <= 1'b0;
    end else begin
      bs_en <= (ir_active == IR_EXTEST);
      hiz_b <= (ir_active != IR_HIGHZ);
      mode  <= chain_sel;
    end
  end

  always_ff @(negedge tclk or negedge trstb) begin
    if (!trstb) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_DR) || (state == SH_IR);
      if (state == SH_DR)      tdo <= dr_tdo;
      else if (state == SH_IR) tdo <= ir_shift[0];
    end
  end

endmodule

// File: doc/jtag_bscan_tap_ice1f.md
# jtag_bscan_tap_ice1f

IEEE 1149.1 TAP controller that owns and drives the right/bottom I/O column boundary-scan chain. It decodes `tms`/`tdi` from the JTAG pads into the chain controls `shift`, `update`, `bs_en`, `hiz_b` and `mode`, and feeds `tdi` into the chain head as `sdi`. It returns the chain tail `sdo`, the bypass bit, the IDCODE or the instruction register on `tdo`. It sits between the JTAG pad buffers and the I/O column `sdi`→`sdo` serial chain.

## Interface
- `IDCODE`, default 32'h1100_0043, device ID; bit 0 must be 1.
- `tclk`  in  1  JTAG clock; `tck_pad` after buffering.
- `trstb`  in  1  asynchronous active-low reset.
- `tms`  in  1  mode select; sampled on the rising edge of `tclk`.
- `tdi`  in  1  serial data in; sampled on the rising edge of `tclk`.
- `tdo`  out  1  serial data out; changes on the falling edge of `tclk`.
- `tdo_en`  out  1  `tdo` pad output enable.
- `sdi`  out  1  chain head data; equals `tdi`.
- `sdo`  in  1  chain tail data.
- `shift`  out  1  chain shift enable.
- `update`  out  1  chain update strobe.
- `bs_en`  out  1  boundary cells drive the pads (EXTEST).
- `hiz_b`  out  1  active-low: tristates all pads (HIGHZ).
- `mode`  out  1  chain cells selected in the data path (EXTEST or SAMPLE).

## Operation
- TAP FSM has the standard 16 states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions follow 1149.1 on `tms` at each rising edge of `tclk`.
- Five consecutive `tms`=1 cycles reach TLR from any state.
- Instruction register is 4 bits:
  - EXTEST = 4'h0
  - SAMPLE = 4'h1
  - HIGHZ = 4'h7
  - IDCODE = 4'hE
  - BYPASS = 4'hF
  - Any other code decodes as BYPASS.
- IR shift register:
  - Loads 4'b0101 in CapIR.
  - Shifts right in ShIR with `tdi` into bit 3; bit 0 goes to `tdo`.
  - Active IR loads from the shift register in UpdIR.
  - Active IR forced to IDCODE in TLR and on reset.
- DR selection by active IR:
  - BYPASS/HIGHZ: 1-bit bypass register, captures 0 in CapDR.
  - IDCODE: 32-bit register, loads `IDCODE` in CapDR, shifts LSB first.
  - EXTEST/SAMPLE: the external chain; `tdo` source is `sdo`.
- `shift` = 1 in ShDR with EXTEST/SAMPLE active; otherwise 0. Chain captures on CapDR clocks while `shift`=0.
- `update` = 1 for exactly the one `tclk` cycle the FSM is in UpdDR with EXTEST/SAMPLE active.
- `bs_en`, `hiz_b`, `mode` decode from the active IR (registered, so glitch-free):
  - `bs_en` = (IR==EXTEST).
  - `hiz_b` = !(IR==HIGHZ).
  - `mode` = (IR==EXTEST || IR==SAMPLE).
- `tdo_en` = 1 only while in ShDR or ShIR.
- `tdo` and `tdo_en` are registered on the falling edge of `tclk`. Outside shift states `tdo` holds its last value.

## Timing
- Reset values (`trstb`=0, asynchronous):
  - State = TLR, IR = IDCODE.
  - `shift`=0, `update`=0, `bs_en`=0, `hiz_b`=1, `mode`=0.
  - `tdo`=0, `tdo_en`=0, bypass bit 0.
- `trstb` asserted mid-shift aborts the operation immediately. No `update` pulse is produced, and the active IR is not changed except by being forced to IDCODE.
- FSM state registers on rising `tclk`. `shift`/`update` are decoded from the state register, so they are valid for the whole cycle the FSM occupies ShDR/UpdDR.
- Active IR takes its new value at the rising edge that leaves UpdIR. `bs_en`/`hiz_b`/`mode` change 1 rising edge after that.
- First `tdo` bit appears at the falling edge after entry to ShDR/ShIR. Data-path latency from `tdi` to `tdo` is (register length) cycles plus a half cycle.
- In PauseDR/PauseIR, shift registers and the chain hold (`shift`=0). Re-entering the shift state resumes without data loss.
- `sdi` is combinational from `tdi`; chain cells sample it on the same rising edge as the TAP.

## Test plan
- Reset, then SelDR/CapDR/ShDR with 32 shifts of `tdi`=0: `tdo` emits 32'h1100_0043 LSB first; `tdo_en`=1 only during those 32 cycles.
- Load IR=4'hF, shift DR pattern 1,0,1,1: `tdo` returns 0,1,0,1 delayed by 1 cycle; `shift`=0 throughout.
- Load IR=4'h0: after UpdIR, `bs_en`=1, `mode`=1, `hiz_b`=1. Shift 8 bits through a modelled 8-cell `sdi`→`sdo` chain: `shift`=1 for 8 cycles, then exactly one `update` pulse in UpdDR.
- Load IR=4'h7: `hiz_b`=0, `bs_en`=0. Then 5 `tms`=1 cycles: TLR reached, IR=IDCODE, `hiz_b` returns to 1.
- Capture IR and shift 4 bits out: `tdo` = 1,0,1,0. Load unused code 4'h3: behaves as BYPASS (1-cycle delay path).
- Assert `trstb` low mid-ShDR in EXTEST: all outputs return to reset values asynchronously with no `update` pulse. After release, `tms`=0 moves the FSM to RTI.
